fir_chan_arbiter: RTL and testbench

- Time-multiplexes one shared 8-bit-in / 20-bit-out FIR engine between the IR and RED photodiode channels of the pulse-oximeter front end.
- The engine is symmetric-coefficient, 22-tap and bank-switched per channel.
- Captures per-channel ADC samples, arbitrates round-robin, and runs the engine start/done handshake with a watchdog.
- Returns each filtered result to its owning channel with a one-cycle valid strobe.
- Sits between the LED/ADC sequencer (100 Hz IR/RED alternation) and the downstream SpO2 ratio logic.

---
 rtl/fir_chan_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_fir_chan_arbiter.sv | 563 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_chan_arbiter.sv
// -----------------------------------------------------------------------------
// fir_chan_arbiter
//
// Shares one FIR engine (8-bit sample in, 20-bit result out, coefficient bank
// selected per channel) between the IR and RED photodiode channels of the
// pulse-oximeter front end.
//
// Each channel has a one-deep pending slot that captures ADC samples.
// A round-robin arbiter grants the engine to a channel with a pending sample.
// The FSM runs the engine start/done handshake under a watchdog.
// The result goes back to the owning channel's output register with a
// one-cycle valid strobe.
//
// Ports
//   CLK_Filter   in   filter clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ir_req       in   strobe: ir_sample valid
//   ir_sample    in   IR ADC value            [DW]
//   red_req      in   strobe: red_sample valid
//   red_sample   in   RED ADC value           [DW]
//   eng_start    out  one-cycle engine start pulse
//   eng_chan     out  engine bank select (0 = IR, 1 = RED)
//   eng_sample   out  sample presented to the engine [DW]
//   eng_done     in   engine completion pulse
//   eng_result   in   engine result, valid with eng_done [OW]
//   ir_out       out  last IR result          [OW]
//   ir_valid     out  one-cycle pulse on ir_out update
//   red_out      out  last RED result         [OW]
//   red_valid    out  one-cycle pulse on red_out update
//   overrun      out  sticky sample-dropped flags, [0] IR, [1] RED
//   timeout_err  out  sticky flag: engine never finished
//   busy         out  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fir_chan_arbiter #(
    parameter int DW      = 8,
    parameter int OW      = 20,
    parameter int TIMEOUT = 16     // legal range 2..255
) (
    input  logic          CLK_Filter,
    input  logic          rst_n,
    input  logic          ir_req,
    input  logic [DW-1:0] ir_sample,
    input  logic          red_req,
    input  logic [DW-1:0] red_sample,
    output logic          eng_start,
    output logic          eng_chan,
    output logic [DW-1:0] eng_sample,
    input  logic          eng_done,
    input  logic [OW-1:0] eng_result,
    output logic [OW-1:0] ir_out,
    output logic          ir_valid,
    output logic [OW-1:0] red_out,
    output logic          red_valid,
    output logic [1:0]    overrun,
    output logic          timeout_err,
    output logic          busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    localparam logic CH_IR  = 1'b0;
    localparam logic CH_RED = 1'b1;

    // The counter is cleared in START and counts WAIT cycles from 0. The abort
    // fires on the WAIT cycle in which it would step to TIMEOUT-1. This places
    // timeout_err TIMEOUT cycles after eng_start.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);

    logic [1:0]    r_state;
    logic          r_pend_ir;
    logic          r_pend_red;
    logic [DW-1:0] r_pend_ir_data;
    logic [DW-1:0] r_pend_red_data;
    logic          r_last_grant;
    logic          r_eng_chan;
    logic [DW-1:0] r_eng_sample;
    logic [7:0]    r_cnt;
    logic [OW-1:0] r_ir_out;
    logic [OW-1:0] r_red_out;
    logic [1:0]    r_overrun;
    logic          r_timeout_err;

    logic          w_grant;
    logic          w_grant_chan;
    logic          w_grant_ir;
    logic          w_grant_red;

    // Arbitration is only evaluated in IDLE. On a tie, the channel that did not
    // win the previous tie is served.
    always_comb begin
        // NOTE: every signal gets a default before the branches, so no path can
        // leave it unassigned and infer a latch.
        w_grant      = 1'b0;
        w_grant_chan = CH_IR;
        if (r_state == S_IDLE) begin
            if (r_pend_ir && r_pend_red) begin
                w_grant      = 1'b1;
                w_grant_chan = ~r_last_grant;
            end else if (r_pend_ir) begin
                w_grant      = 1'b1;
                w_grant_chan = CH_IR;
            end else if (r_pend_red) begin
                w_grant      = 1'b1;
                w_grant_chan = CH_RED;
            end
        end
    end

    assign w_grant_ir  = w_grant && (w_grant_chan == CH_IR);
    assign w_grant_red = w_grant && (w_grant_chan == CH_RED);

    // Sample capture. A request on the grant edge of its own channel refills
    // the slot just handed to the engine, so nothing is lost and there is no
    // overrun.
    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data slots are reset as well, so eng_sample never
            // carries X even before the first request.
            r_pend_ir       <= 1'b0;
            r_pend_red      <= 1'b0;
            r_pend_ir_data  <= '0;
            r_pend_red_data <= '0;
            r_overrun       <= 2'b00;
        end else begin
            // NOTE: state registers use non-blocking assignments, so every
            // process reads pre-edge values regardless of evaluation order.
            if (ir_req) begin
                r_pend_ir      <= 1'b1;
                r_pend_ir_data <= ir_sample;
                if (r_pend_ir && !w_grant_ir) begin
                    r_overrun[0] <= 1'b1;
                end
            end else if (w_grant_ir) begin
                r_pend_ir <= 1'b0;
            end

            if (red_req) begin
                r_pend_red      <= 1'b1;
                r_pend_red_data <= red_sample;
                if (r_pend_red && !w_grant_red) begin
                    r_overrun[1] <= 1'b1;
                end
            end else if (w_grant_red) begin
                r_pend_red <= 1'b0;
            end
        end
    end

    // Engine handshake FSM
    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_last_grant  <= CH_RED;      // IR wins the first tie
            r_eng_chan    <= CH_IR;
            r_eng_sample  <= '0;
            r_cnt         <= '0;
            r_ir_out      <= '0;
            r_red_out     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state      <= S_START;
                        r_eng_chan   <= w_grant_chan;
                        r_eng_sample <= w_grant_chan ? r_pend_red_data : r_pend_ir_data;
                        // Only a real tie moves the round-robin pointer.
                        if (r_pend_ir && r_pend_red) begin
                            r_last_grant <= w_grant_chan;
                        end
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (eng_done) begin
                        if (r_eng_chan == CH_IR) begin
                            r_ir_out <= eng_result;
                        end else begin
                            r_red_out <= eng_result;
                        end
                        r_state <= S_WB;
                    end else if (r_cnt == CNT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                S_WB: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign eng_start   = (r_state == S_START);
    assign eng_chan    = r_eng_chan;
    assign eng_sample  = r_eng_sample;
    assign ir_out      = r_ir_out;
    assign red_out     = r_red_out;
    assign ir_valid    = (r_state == S_WB) && (r_eng_chan == CH_IR);
    assign red_valid   = (r_state == S_WB) && (r_eng_chan == CH_RED);
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir_chan_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fir_chan_arbiter
//
// Bench for fir_chan_arbiter. Directed scenarios cover the documented cases:
// single request, round robin, overrun, watchdog, grant-edge refill and
// reset during WAIT. A randomized run follows and is checked every cycle
// against a timestamp-based reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fir_chan_arbiter;

    localparam int DW      = 8;
    localparam int OW      = 20;
    localparam int TIMEOUT = 16;
    localparam int INF     = 2147483647;

    logic          CLK_Filter = 1'b0;
    logic          rst_n;
    logic          ir_req;
    logic [DW-1:0] ir_sample;
    logic          red_req;
    logic [DW-1:0] red_sample;
    logic          eng_start;
    logic          eng_chan;
    logic [DW-1:0] eng_sample;
    logic          eng_done;
    logic [OW-1:0] eng_result;
    logic [OW-1:0] ir_out;
    logic          ir_valid;
    logic [OW-1:0] red_out;
    logic          red_valid;
    logic [1:0]    overrun;
    logic          timeout_err;
    logic          busy;

    logic [55:0]   all_outs;
    assign all_outs = {eng_start, eng_chan, eng_sample, ir_out, red_out,
                       ir_valid, red_valid, overrun, timeout_err, busy};

    always #5 CLK_Filter = ~CLK_Filter;

    fir_chan_arbiter #(.DW(DW), .OW(OW), .TIMEOUT(TIMEOUT)) dut (
        .CLK_Filter  (CLK_Filter),
        .rst_n       (rst_n),
        .ir_req      (ir_req),
        .ir_sample   (ir_sample),
        .red_req     (red_req),
        .red_sample  (red_sample),
        .eng_start   (eng_start),
        .eng_chan    (eng_chan),
        .eng_sample  (eng_sample),
        .eng_done    (eng_done),
        .eng_result  (eng_result),
        .ir_out      (ir_out),
        .ir_valid    (ir_valid),
        .red_out     (red_out),
        .red_valid   (red_valid),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ---------------- reference model (timestamps, not states) -------------
    // A service is described by the cycle its start pulse appears (m_start),
    // the cycle its valid strobe appears (m_valid_cyc) and the first cycle the
    // arbiter is free again (m_idle_from, INF while the outcome is unknown).
    bit            m_pend [2];
    logic [DW-1:0] m_data [2];
    logic [OW-1:0] m_out  [2];
    bit            m_last;
    bit [1:0]      m_ovr;
    bit            m_terr;
    bit            m_chan;
    logic [DW-1:0] m_sample;
    int            m_idle_from;
    int            m_start;
    int            m_valid_cyc;

    bit e_start, e_busy, e_ir_valid, e_red_valid, e_hold;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pend[c] = 1'b0;
            m_data[c] = '0;
            m_out[c]  = '0;
        end
        m_last      = 1'b1;
        m_ovr       = 2'b00;
        m_terr      = 1'b0;
        m_chan      = 1'b0;
        m_sample    = '0;
        m_idle_from = 0;
        m_start     = -1;
        m_valid_cyc = -1;
        cyc         = 0;
    endtask

    task automatic model_predict();
        e_start     = (cyc == m_start);
        e_busy      = (cyc < m_idle_from);
        e_ir_valid  = (cyc == m_valid_cyc) && !m_chan;
        e_red_valid = (cyc == m_valid_cyc) && m_chan;
        e_hold      = (m_start >= 0) && (cyc >= m_start) && (cyc < m_idle_from)
                      && (cyc != m_valid_cyc);
    endtask

    // Applies the inputs of the current cycle at its closing clock edge.
    task automatic model_update();
        bit            g;
        bit            gch;
        bit            req [2];
        logic [DW-1:0] smp [2];
        req[0] = ir_req;  smp[0] = ir_sample;
        req[1] = red_req; smp[1] = red_sample;
        g   = (cyc >= m_idle_from) && (m_pend[0] || m_pend[1]);
        gch = 1'b0;
        if (g) begin
            if (m_pend[0] && m_pend[1]) begin
                gch    = !m_last;
                m_last = gch;
            end else begin
                gch = m_pend[1];
            end
            m_chan      = gch;
            m_sample    = m_data[gch];
            m_start     = cyc + 1;
            m_idle_from = INF;
            m_valid_cyc = -1;
        end else if (m_idle_from == INF && cyc > m_start) begin
            if (eng_done) begin
                m_out[m_chan] = eng_result;
                m_valid_cyc   = cyc + 1;
                m_idle_from   = cyc + 2;
            end else if (cyc == m_start + TIMEOUT - 1) begin
                m_terr      = 1'b1;
                m_idle_from = cyc + 1;
            end
        end
        for (int c = 0; c < 2; c++) begin
            if (req[c]) begin
                if (m_pend[c] && !(g && gch == c[0])) m_ovr[c] = 1'b1;
                m_pend[c] = 1'b1;
                m_data[c] = smp[c];
            end else if (g && gch == c[0]) begin
                m_pend[c] = 1'b0;
            end
        end
    endtask

    // One clock cycle: inputs set by the caller are consumed, strobes drop.
    task automatic tick();
        model_update();
        @(posedge CLK_Filter);
        @(negedge CLK_Filter);
        cyc++;
        ir_req   = 1'b0;
        red_req  = 1'b0;
        eng_done = 1'b0;
        model_predict();
    endtask

    task automatic apply_reset();
        @(negedge CLK_Filter);
        rst_n      = 1'b0;
        ir_req     = 1'b0;
        red_req    = 1'b0;
        eng_done   = 1'b0;
        ir_sample  = '0;
        red_sample = '0;
        eng_result = '0;
        @(negedge CLK_Filter);
        @(negedge CLK_Filter);
        rst_n = 1'b1;
        model_reset();
        model_predict();
    endtask

    // Waits (bounded) for eng_start and answers with done D cycles later.
    // On return the bench sits in the write-back cycle.
    task automatic serve(input int d, input logic [OW-1:0] res,
                         output bit ok, output bit ch, output logic [DW-1:0] smp);
        ok  = 1'b0;
        ch  = 1'b0;
        smp = '0;
        for (int i = 0; i < 40; i++) begin
            if (eng_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            ch  = eng_chan;
            smp = eng_sample;
            repeat (d + 1) tick();
            eng_done   = 1'b1;
            eng_result = res;
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge CLK_Filter);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (all_outs !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_asserted: outputs=%0h want 0", all_outs);
        end
        apply_reset();
        n_checks++;
        if (all_outs !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_released: outputs=%0h want 0", all_outs);
        end
        tick();
        n_checks++;
        if (all_outs !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_idle: outputs=%0h want 0", all_outs);
        end
    endtask

    task automatic test_single_ir();
        apply_reset();
        ir_req = 1'b1; ir_sample = 8'h5A;
        tick();
        n_checks++;
        if (eng_start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_start_early: eng_start=%b want 0", eng_start);
        end
        tick();
        n_checks++;
        if (eng_start !== 1'b1) begin
            n_fail++;
            $display("FAIL single_start_latency: eng_start=%b want 1", eng_start);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if ({eng_start, busy, eng_chan, eng_sample, red_valid} !== {1'b0, 1'b1, 1'b0, 8'h5A, 1'b0}) begin
                n_fail++;
                $display("FAIL single_wait_hold k=%0d: start=%b busy=%b chan=%b sample=%0h red_valid=%b want 0 1 0 5a 0",
                         k, eng_start, busy, eng_chan, eng_sample, red_valid);
            end
            if (k == 4) begin
                eng_done = 1'b1; eng_result = 20'h01234;
            end
        end
        tick();
        n_checks++;
        if ({ir_valid, red_valid, ir_out} !== {1'b1, 1'b0, 20'h01234}) begin
            n_fail++;
            $display("FAIL single_result: ir_valid=%b red_valid=%b ir_out=%0h want 1 0 01234",
                     ir_valid, red_valid, ir_out);
        end
        tick();
        n_checks++;
        if ({ir_valid, red_valid, busy, ir_out} !== {1'b0, 1'b0, 1'b0, 20'h01234}) begin
            n_fail++;
            $display("FAIL single_after: ir_valid=%b red_valid=%b busy=%b ir_out=%0h want 0 0 0 01234",
                     ir_valid, red_valid, busy, ir_out);
        end
    endtask

    task automatic test_round_robin();
        bit ok, ch;
        logic [DW-1:0] smp;
        logic [DW-1:0] want_smp [4] = '{8'h10, 8'h20, 8'h40, 8'h30};
        bit            want_ch  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        for (int j = 0; j < 4; j++) begin
            if (j == 0 || j == 2) begin
                ir_req  = 1'b1; ir_sample  = (j == 0) ? 8'h10 : 8'h30;
                red_req = 1'b1; red_sample = (j == 0) ? 8'h20 : 8'h40;
                tick();
            end
            serve(1 + j, 20'hA0000 + 20'(j), ok, ch, smp);
            n_checks++;
            if (!ok || ch !== want_ch[j] || smp !== want_smp[j]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: started=%0d chan=%0d sample=%0h want 1 %0d %0h",
                         j, ok, ch, smp, want_ch[j], want_smp[j]);
            end
            n_checks++;
            if ((want_ch[j] ? {red_valid, ir_valid, red_out} : {ir_valid, red_valid, ir_out})
                !== {1'b1, 1'b0, 20'hA0000 + 20'(j)}) begin
                n_fail++;
                $display("FAIL rr_result[%0d]: ir_valid=%b red_valid=%b ir_out=%0h red_out=%0h want result %0h on chan %0d",
                         j, ir_valid, red_valid, ir_out, red_out, 20'hA0000 + 20'(j), want_ch[j]);
            end
        end
    endtask

    task automatic test_overrun();
        bit found, ok, ch;
        logic [DW-1:0] smp;
        apply_reset();
        red_req = 1'b1; red_sample = 8'h55;
        tick();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (eng_start === 1'b1) begin found = 1'b1; break; end
            tick();
        end
        n_checks++;
        if (!found || eng_chan !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_red_start: started=%0d chan=%b want 1 1", found, eng_chan);
        end
        for (int k = 0; k <= 8; k++) begin
            if (k == 0 || k == 2 || k == 4) begin
                ir_req = 1'b1; ir_sample = 8'(k / 2 + 1);
            end
            if (k == 8) begin
                eng_done = 1'b1; eng_result = 20'h5A5A5;
            end
            tick();
        end
        n_checks++;
        if ({red_valid, red_out, overrun} !== {1'b1, 20'h5A5A5, 2'b01}) begin
            n_fail++;
            $display("FAIL ovr_flag: red_valid=%b red_out=%0h overrun=%b want 1 5a5a5 01",
                     red_valid, red_out, overrun);
        end
        serve(2, 20'h00333, ok, ch, smp);
        n_checks++;
        if (!ok || ch !== 1'b0 || smp !== 8'h03) begin
            n_fail++;
            $display("FAIL ovr_latest_sample: started=%0d chan=%0d sample=%0h want 1 0 03", ok, ch, smp);
        end
        n_checks++;
        if ({ir_valid, ir_out, overrun} !== {1'b1, 20'h00333, 2'b01}) begin
            n_fail++;
            $display("FAIL ovr_ir_result: ir_valid=%b ir_out=%0h overrun=%b want 1 00333 01",
                     ir_valid, ir_out, overrun);
        end
    endtask

    task automatic test_timeout();
        bit found, seen_valid, ok, ch;
        logic [DW-1:0] smp;
        apply_reset();
        ir_req = 1'b1; ir_sample = 8'h77;
        tick();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (eng_start === 1'b1) begin found = 1'b1; break; end
            tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL to_start: eng_start never seen, want a start within 10 cycles");
        end
        red_req = 1'b1; red_sample = 8'h66;
        seen_valid = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (ir_valid || red_valid) seen_valid = 1'b1;
            n_checks++;
            if (k < TIMEOUT) begin
                if ({timeout_err, busy} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL to_waiting k=%0d: timeout_err=%b busy=%b want 0 1", k, timeout_err, busy);
                end
            end else if ({timeout_err, busy} !== 2'b10) begin
                n_fail++;
                $display("FAIL to_abort k=%0d: timeout_err=%b busy=%b want 1 0", k, timeout_err, busy);
            end
        end
        n_checks++;
        if (seen_valid || ir_out !== 20'h0) begin
            n_fail++;
            $display("FAIL to_no_result: valid_seen=%0d ir_out=%0h want 0 0", seen_valid, ir_out);
        end
        serve(1, 20'hC0FFE, ok, ch, smp);
        n_checks++;
        if (!ok || ch !== 1'b1 || smp !== 8'h66) begin
            n_fail++;
            $display("FAIL to_next_grant: started=%0d chan=%0d sample=%0h want 1 1 66", ok, ch, smp);
        end
        n_checks++;
        if ({red_valid, red_out, timeout_err} !== {1'b1, 20'hC0FFE, 1'b1}) begin
            n_fail++;
            $display("FAIL to_next_result: red_valid=%b red_out=%0h timeout_err=%b want 1 c0ffe 1",
                     red_valid, red_out, timeout_err);
        end
    endtask

    task automatic test_coincident();
        bit ok, ch;
        logic [DW-1:0] smp;
        apply_reset();
        ir_req = 1'b1; ir_sample = 8'hA1;
        tick();
        ir_req = 1'b1; ir_sample = 8'hB2;   // lands on the IR grant edge
        tick();
        serve(3, 20'h000A1, ok, ch, smp);
        n_checks++;
        if (!ok || ch !== 1'b0 || smp !== 8'hA1 || ir_out !== 20'h000A1) begin
            n_fail++;
            $display("FAIL coin_first: started=%0d chan=%0d sample=%0h ir_out=%0h want 1 0 a1 000a1",
                     ok, ch, smp, ir_out);
        end
        serve(0, 20'h000B2, ok, ch, smp);
        n_checks++;
        if (!ok || ch !== 1'b0 || smp !== 8'hB2 || ir_valid !== 1'b1 || ir_out !== 20'h000B2) begin
            n_fail++;
            $display("FAIL coin_second: started=%0d chan=%0d sample=%0h ir_valid=%b ir_out=%0h want 1 0 b2 1 000b2",
                     ok, ch, smp, ir_valid, ir_out);
        end
        tick();
        tick();
        n_checks++;
        if ({busy, overrun} !== 3'b000) begin
            n_fail++;
            $display("FAIL coin_no_overrun: busy=%b overrun=%b want 0 00", busy, overrun);
        end
    endtask

    task automatic test_reset_in_wait();
        bit found, ok, ch;
        logic [DW-1:0] smp;
        apply_reset();
        red_req = 1'b1; red_sample = 8'h11;
        tick();
        serve(1, 20'hFFFFF, ok, ch, smp);
        ir_req = 1'b1; ir_sample = 8'h3C;
        tick();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (eng_start === 1'b1) begin found = 1'b1; break; end
            tick();
        end
        red_req = 1'b1; red_sample = 8'h01;
        tick();
        red_req = 1'b1; red_sample = 8'h02;
        tick();
        tick();
        n_checks++;
        if (!ok || !found || {busy, eng_sample, red_out, overrun} !== {1'b1, 8'h3C, 20'hFFFFF, 2'b10}) begin
            n_fail++;
            $display("FAIL rstw_setup: served=%0d started=%0d busy=%b sample=%0h red_out=%0h overrun=%b want 1 1 1 3c fffff 10",
                     ok, found, busy, eng_sample, red_out, overrun);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (all_outs !== 56'd0) begin
            n_fail++;
            $display("FAIL rstw_async_clear: outputs=%0h want 0", all_outs);
        end
        @(negedge CLK_Filter);
        rst_n = 1'b1;
        model_reset();
        model_predict();
        eng_done = 1'b1; eng_result = 20'h12345;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({ir_valid, red_valid, busy, ir_out, red_out} !== 43'd0) begin
                n_fail++;
                $display("FAIL rstw_stale_done k=%0d: ir_valid=%b red_valid=%b busy=%b ir_out=%0h red_out=%0h want all 0",
                         k, ir_valid, red_valid, busy, ir_out, red_out);
            end
        end
    endtask

    task automatic test_random();
        int sched;
        apply_reset();
        sched = -1;
        for (int i = 0; i < 3000; i++) begin
            if (e_start) sched = cyc + 1 + $urandom_range(0, 17);
            ir_req     = ($urandom_range(0, 4) == 0);
            ir_sample  = 8'($urandom);
            red_req    = ($urandom_range(0, 4) == 0);
            red_sample = 8'($urandom);
            eng_done   = (cyc == sched) || ($urandom_range(0, 24) == 0);
            eng_result = 20'($urandom);

            n_checks++;
            if (eng_start !== e_start) begin
                n_fail++;
                $display("FAIL rnd_start cyc=%0d: got %b want %b", cyc, eng_start, e_start);
            end
            n_checks++;
            if (busy !== e_busy) begin
                n_fail++;
                $display("FAIL rnd_busy cyc=%0d: got %b want %b", cyc, busy, e_busy);
            end
            n_checks++;
            if ({ir_valid, red_valid} !== {e_ir_valid, e_red_valid}) begin
                n_fail++;
                $display("FAIL rnd_valid cyc=%0d: got ir=%b red=%b want ir=%b red=%b",
                         cyc, ir_valid, red_valid, e_ir_valid, e_red_valid);
            end
            n_checks++;
            if (ir_out !== m_out[0]) begin
                n_fail++;
                $display("FAIL rnd_ir_out cyc=%0d: got %0h want %0h", cyc, ir_out, m_out[0]);
            end
            n_checks++;
            if (red_out !== m_out[1]) begin
                n_fail++;
                $display("FAIL rnd_red_out cyc=%0d: got %0h want %0h", cyc, red_out, m_out[1]);
            end
            n_checks++;
            if ({overrun, timeout_err} !== {m_ovr, m_terr}) begin
                n_fail++;
                $display("FAIL rnd_flags cyc=%0d: got overrun=%b timeout_err=%b want %b %b",
                         cyc, overrun, timeout_err, m_ovr, m_terr);
            end
            if (e_hold) begin
                n_checks++;
                if ({eng_chan, eng_sample} !== {m_chan, m_sample}) begin
                    n_fail++;
                    $display("FAIL rnd_eng_hold cyc=%0d: got chan=%b sample=%0h want %b %0h",
                             cyc, eng_chan, eng_sample, m_chan, m_sample);
                end
            end
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        ir_req     = 1'b0;
        red_req    = 1'b0;
        eng_done   = 1'b0;
        ir_sample  = '0;
        red_sample = '0;
        eng_result = '0;
        model_reset();
        test_reset();
        test_single_ir();
        test_round_robin();
        test_overrun();
        test_timeout();
        test_coincident();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
